// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request channels, register-file write port and RAW hazard query
// shared between the two writeback sources, the arbiter and decode.
interface regfile_wb_arbiter_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  logic          s0_valid;
  logic          s0_ready;
  logic [AW-1:0] s0_addr;
  logic [DW-1:0] s0_data;
  logic          s1_valid;
  logic          s1_ready;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_data;
  logic          we3;
  logic [AW-1:0] addr3;
  logic [DW-1:0] writeData3;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic          pend1;
  logic          pend2;
  logic          err;
  logic          idle;

  modport slave (
    input  s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data, rd_addr1, rd_addr2,
    output s0_ready, s1_ready, we3, addr3, writeData3, pend1, pend2, err, idle
  );

  modport master (
    output s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data, rd_addr1, rd_addr2,
    input  s0_ready, s1_ready, we3, addr3, writeData3, pend1, pend2, err, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source round-robin writeback arbiter with per-source FIFOs and a registered write stage.
// Optional REGFILE_ZERO_REG_EN: register 0 is never written and never reported as pending.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 6,
  parameter int DW    = 32,
  parameter int NREGS = 32
) (
  input  logic               clk,
  input  logic               reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW:0] LIM = (AW+1)'(NREGS);

  logic [1:0]    w_vld;
  logic [AW-1:0] w_in_addr [2];
  logic [DW-1:0] w_in_data [2];
  logic [AW-1:0] w_rda [2];

  logic [CW-1:0] r_cnt [2];
  logic [PW-1:0] r_rd  [2];
  logic [PW-1:0] r_wr  [2];
  logic [AW-1:0] r_faddr [2][DEPTH];
  logic [DW-1:0] r_fdata [2][DEPTH];

  logic [1:0]    w_rdy, w_ne, w_push, w_pop;
  logic          r_rr, w_sel, w_any_pop, w_oor, w_wr;
  logic [AW-1:0] w_hd_addr;
  logic [DW-1:0] w_hd_data;
  logic [1:0]    w_pend;

  logic          r_we, r_err;
  logic [AW-1:0] r_a3;
  logic [DW-1:0] r_d3;

  assign w_vld        = {bus.s1_valid, bus.s0_valid};
  assign w_in_addr[0] = bus.s0_addr;
  assign w_in_addr[1] = bus.s1_addr;
  assign w_in_data[0] = bus.s0_data;
  assign w_in_data[1] = bus.s1_data;
  assign w_rda[0]     = bus.rd_addr1;
  assign w_rda[1]     = bus.rd_addr2;

  // Ready comes from the start-of-cycle count only, so a full FIFO never takes a push while popping.
  always_comb begin
    w_rdy = '0;
    w_ne  = '0;
    for (int s = 0; s < 2; s++) begin
      w_rdy[s] = !reset && (r_cnt[s] < CW'(DEPTH));
      w_ne[s]  = (r_cnt[s] != '0);
    end
  end

  assign w_push    = w_vld & w_rdy;
  assign w_sel     = w_ne[1] && (!w_ne[0] || r_rr);
  assign w_pop[0]  = w_ne[0] && !w_sel;
  assign w_pop[1]  = w_ne[1] && w_sel;
  assign w_any_pop = |w_ne;
  assign w_hd_addr = w_sel ? r_faddr[1][r_rd[1]] : r_faddr[0][r_rd[0]];
  assign w_hd_data = w_sel ? r_fdata[1][r_rd[1]] : r_fdata[0][r_rd[0]];

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (w_push[s]) begin
        r_faddr[s][r_wr[s]] <= w_in_addr[s];
        r_fdata[s][r_wr[s]] <= w_in_data[s];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        r_cnt[s] <= '0;
        r_rd[s]  <= '0;
        r_wr[s]  <= '0;
      end
      r_rr <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        r_cnt[s] <= r_cnt[s] + CW'(w_push[s]) - CW'(w_pop[s]);
        if (w_push[s]) r_wr[s] <= r_wr[s] + 1'b1;
        if (w_pop[s])  r_rd[s] <= r_rd[s] + 1'b1;
      end
      if (w_ne[0] && w_ne[1]) r_rr <= !w_sel;
    end
  end

  always_comb begin
    w_oor = ({1'b0, w_hd_addr} >= LIM);
`ifdef REGFILE_ZERO_REG_EN
    w_wr  = w_any_pop && !w_oor && (w_hd_addr != '0);
`else
    w_wr  = w_any_pop && !w_oor;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we  <= 1'b0;
      r_a3  <= '0;
      r_d3  <= '0;
      r_err <= 1'b0;
    end else begin
      r_we <= w_wr;
      if (w_wr) begin
        r_a3 <= w_hd_addr;
        r_d3 <= w_hd_data;
      end
      if (w_any_pop && w_oor) r_err <= 1'b1;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    w_pend = '0;
    for (int p = 0; p < 2; p++) begin
      if (r_we && (r_a3 == w_rda[p])) w_pend[p] = 1'b1;
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (({1'b0, PW'(i) - r_rd[s]} < r_cnt[s]) && (r_faddr[s][i] == w_rda[p]))
            w_pend[p] = 1'b1;
        end
      end
`ifdef REGFILE_ZERO_REG_EN
      if (w_rda[p] == '0) w_pend[p] = 1'b0;
`endif
    end
  end

  assign bus.s0_ready   = w_rdy[0];
  assign bus.s1_ready   = w_rdy[1];
  assign bus.we3        = r_we;
  assign bus.addr3      = r_a3;
  assign bus.writeData3 = r_d3;
  assign bus.pend1      = w_pend[0];
  assign bus.pend2      = w_pend[1];
  assign bus.err        = r_err;
  assign bus.idle       = !w_ne[0] && !w_ne[1] && !r_we;
endmodule
